lap_sampler: RTL and testbench
==============================

# lap_sampler

Front end of the stopwatch, directly upstream of the lap stash. It conditions three push buttons (run/stop, lap, next), runs a seconds counter in two-digit BCD (00–59), and produces the capture and browse strobes. Its `sample_in`, `sample_in_valid` and `next_sample` outputs wire one-to-one onto the stash's like-named inputs. `time_bcd` also feeds the display path.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per one-second tick. Must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button level is accepted. Must be ≥ 1.
- `clk`  in  1  system clock; every register updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_run`  in  1  raw button; each press toggles run/stop.
- `btn_lap`  in  1  raw button; captures a lap while running, clears time while stopped.
- `btn_next`  in  1  raw button; browses stored laps.
- `time_bcd`  out  8  current time; `[7:4]` is tens (0–5), `[3:0]` is ones (0–9).
- `running`  out  1  high while in RUNNING.
- `sample_in`  out  8  captured time; valid while `sample_in_valid` is high.
- `sample_in_valid`  out  1  one-cycle lap-capture strobe.
- `next_sample`  out  1  one-cycle browse strobe.

## Operation
- **Reset values:**
  - `time_bcd`=8'h00, `running`=0, `sample_in`=8'h00, `sample_in_valid`=0, `next_sample`=0.
  - State is IDLE and the prescaler is 0.
  - Synchroniser and edge registers reset to 1, so a button held through reset release produces no press.
- **Button conditioning**, applied to each button independently:
  - 2-flop synchroniser, then debounce (see Configuration), then rising-edge detect.
  - The result is a one-cycle internal press pulse.
  - A held button yields exactly one press; releasing it yields none.
- **FSM:**
  - IDLE: on run press go to RUNNING and clear the prescaler. On lap press clear `time_bcd` to 00 and clear the prescaler; no strobe is issued.
  - RUNNING: on run press go to IDLE; `time_bcd` and the prescaler hold. On lap press set `sample_in` to `time_bcd` and pulse `sample_in_valid`; counting continues.
- **Prescaler:** counts 0..TICK_DIV-1 in RUNNING only; the tick occurs at the wrap.
- **BCD increment on tick:**
  - Ones 9 → 0 carries into tens.
  - 8'h59 → 8'h00.
  - Non-BCD values are unreachable.
- **next_sample:** a next press pulses it for one cycle in any state.
- **Simultaneous events:**
  - Lap press and tick in the same cycle: `sample_in` takes the pre-increment value, and the time still increments.
  - Run press and lap press in the same cycle: the lap is evaluated against the state before the toggle.
  - Presses on different buttons in the same cycle are all honoured.
- **Reset mid-operation:** all outputs return to reset values immediately (asynchronous). A strobe in flight is dropped.

## Timing
- Let E be the first edge at which a raw button is sampled high.
- Without debounce: the output strobe (or state change) is registered at edge E+2 and deasserts at E+3.
- With debounce: the same sequence is delayed by DEBOUNCE_CYCLES, i.e. the strobe asserts at E+2+DEBOUNCE_CYCLES.
- Tick latency: `time_bcd` changes at the edge where the prescaler wraps. First change is TICK_DIV cycles after the RUNNING entry edge.
- `running` changes at the same edge as the state.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- **`LAP_SAMPLER_DEBOUNCE_EN` defined:**
  - Each synchronised level passes through a counter filter.
  - A new level is accepted only after DEBOUNCE_CYCLES consecutive identical samples.
  - Any bounce restarts the count.
- **`LAP_SAMPLER_DEBOUNCE_EN` undefined:**
  - No filter; `DEBOUNCE_CYCLES` is ignored.
  - The synchronised level goes straight to the edge detector.
  - Latency is as in Timing without debounce.

## Structure
- **Package `lap_sampler_pkg`:**
  - State enum {IDLE, RUNNING}.
  - BCD limits ONES_MAX=4'd9 and TENS_MAX=4'd5.
  - Reset value TIME_ZERO=8'h00.
- **Sub-module `btn_cond`:**
  - Synchroniser, optional debounce, and edge detect.
  - Carries parameter DEBOUNCE_CYCLES.
  - Instantiated three times.
- The top level contains the FSM, prescaler, BCD counter and output registers.

## Test plan
Test values: TICK_DIV=4, DEBOUNCE_CYCLES=3, macro defined unless stated.
- Reset held, buttons toggling → all outputs 0 and `running`=0 throughout. Button held across reset release → no strobe.
- Run press, then 4·4 cycles → `time_bcd`=8'h04. After 60 ticks → 8'h00. After 10 more ticks → 8'h10.
- Running, lap press at `time_bcd`=8'h23 → `sample_in_valid` high exactly one cycle with `sample_in`=8'h23; counting continues to 8'h24.
- Run press (stop) at 8'h31, wait 40 cycles → `time_bcd` holds 8'h31. Lap press → `time_bcd`=8'h00 and `sample_in_valid` never asserts.
- `btn_next` held 50 cycles → exactly one `next_sample` pulse, at E+5. 2-cycle glitch → no pulse. Macro undefined: pulse at E+2.
- Lap press timed so its strobe edge coincides with a tick at 8'h09 → `sample_in`=8'h09 and `time_bcd`=8'h10. Reset asserted mid-strobe → `sample_in_valid`=0 at once.

Source files
------------

// File: rtl/lap_sampler_pkg.sv
// Shared types and constants for the stopwatch front end (lap_sampler).
package lap_sampler_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } state_e;

  localparam logic [3:0] ONES_MAX  = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [7:0] TIME_ZERO = 8'h00;

  // Two-digit BCD seconds increment, 59 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] t);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = t[7:4];
    ones = t[3:0];
    if (ones != ONES_MAX) return {tens, ones + 4'd1};
    if (tens != TENS_MAX) return {tens + 4'd1, 4'd0};
    return TIME_ZERO;
  endfunction

endpackage

// File: rtl/lap_sampler_btn_cond.sv
// Button conditioner: 2-flop synchroniser, optional debounce filter
// (LAP_SAMPLER_DEBOUNCE_EN) and rising-edge detect to a one-cycle press.
module btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic prev_q;

  // Reset high so a button held through reset release is not a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef LAP_SAMPLER_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Accept a new level on its DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
      else                                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES != 0);
  assign level           = sync2_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= 1'b1;
    else       prev_q <= level;
  end

  assign press_o = level & ~prev_q;

endmodule

// File: rtl/lap_sampler.sv
// Stopwatch front end: button conditioning, run/stop FSM, seconds prescaler,
// BCD 00-59 counter and lap/browse strobes. Debounce via LAP_SAMPLER_DEBOUNCE_EN.
module lap_sampler
  import lap_sampler_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_lap,
  input  logic       btn_next,
  output logic [7:0] time_bcd,
  output logic       running,
  output logic [7:0] sample_in,
  output logic       sample_in_valid,
  output logic       next_sample
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic run_press;
  logic lap_press;
  logic next_press;

  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk_i(clk), .rst_i(reset), .btn_i(btn_run), .press_o(run_press)
  );
  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk_i(clk), .rst_i(reset), .btn_i(btn_lap), .press_o(lap_press)
  );
  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk_i(clk), .rst_i(reset), .btn_i(btn_next), .press_o(next_press)
  );

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    time_q, time_d;
  logic [7:0]    sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          next_q, next_d;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    time_d   = time_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    next_d   = next_press;
    case (state_q)
      IDLE: begin
        if (lap_press) begin
          time_d  = TIME_ZERO;
          presc_d = '0;
        end
        if (run_press) begin
          state_d = RUNNING;
          presc_d = '0;
        end
      end
      RUNNING: begin
        // Lap captures the pre-tick value; a stop freezes both time and prescaler.
        if (lap_press) begin
          sample_d = time_q;
          valid_d  = 1'b1;
        end
        if (run_press) begin
          state_d = IDLE;
        end else if (presc_q == PW'(TICK_DIV - 1)) begin
          presc_d = '0;
          time_d  = bcd_inc(time_q);
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      time_q   <= TIME_ZERO;
      sample_q <= TIME_ZERO;
      valid_q  <= 1'b0;
      next_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      time_q   <= time_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      next_q   <= next_d;
    end
  end

  assign time_bcd        = time_q;
  assign running         = (state_q == RUNNING);
  assign sample_in       = sample_q;
  assign sample_in_valid = valid_q;
  assign next_sample     = next_q;

endmodule

// File: tb/tb_lap_sampler.sv
// Directed, table-driven bench for lap_sampler (TICK_DIV=4, DEBOUNCE_CYCLES=3).
module tb_lap_sampler;

`ifdef LAP_SAMPLER_DEBOUNCE_EN
  localparam int unsigned LAT = 5;
`else
  localparam int unsigned LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_next = 1'b0;
  logic [7:0] time_bcd;
  logic       running;
  logic [7:0] sample_in;
  logic       sample_in_valid;
  logic       next_sample;

  int unsigned checks = 0;
  int unsigned errors = 0;

  lap_sampler #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .btn_run(btn_run), .btn_lap(btn_lap), .btn_next(btn_next),
    .time_bcd(time_bcd), .running(running), .sample_in(sample_in),
    .sample_in_valid(sample_in_valid), .next_sample(next_sample)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {OP_WAIT, OP_RUN, OP_LAP, OP_NEXT, OP_RUNLAP} op_e;
  typedef struct {
    op_e         op;
    int unsigned cycles;
    logic [7:0]  exp_time;
    logic        exp_run;
    int unsigned exp_valid;
    logic [7:0]  exp_sample;
    int unsigned exp_next;
    logic [7:0]  exp_tcap;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 16-cycle press; the raise is placed so the strobe edge is always the 6th posedge.
  task automatic do_press(input logic r, input logic l, input logic n,
                          output int unsigned nv, output int unsigned nn,
                          output logic [7:0] cap, output logic [7:0] tcap,
                          output int unsigned pos);
    nv = 0; nn = 0; cap = 8'h00; tcap = 8'h00; pos = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5 - LAT) begin btn_run = r; btn_lap = l; btn_next = n; end
      if (k == 8) begin btn_run = 1'b0; btn_lap = 1'b0; btn_next = 1'b0; end
      @(negedge clk);
      if (sample_in_valid) begin nv++; cap = sample_in; tcap = time_bcd; pos = k + 1; end
      if (next_sample) begin nn++; pos = k + 1; end
    end
  endtask

  initial begin
    int unsigned nv, nn, pos, cnt;
    logic [7:0] cap, tcap;

    vecs[0]  = '{OP_RUN,    0,   8'h02, 1'b1, 0, 8'h00, 0, 8'h00};
    vecs[1]  = '{OP_WAIT,   6,   8'h04, 1'b1, 0, 8'h00, 0, 8'h00};
    vecs[2]  = '{OP_WAIT,   72,  8'h22, 1'b1, 0, 8'h00, 0, 8'h00};
    vecs[3]  = '{OP_LAP,    0,   8'h26, 1'b1, 1, 8'h23, 0, 8'h23};
    vecs[4]  = '{OP_WAIT,   132, 8'h59, 1'b1, 0, 8'h00, 0, 8'h00};
    vecs[5]  = '{OP_WAIT,   4,   8'h00, 1'b1, 0, 8'h00, 0, 8'h00};
    vecs[6]  = '{OP_WAIT,   34,  8'h08, 1'b1, 0, 8'h00, 0, 8'h00};
    vecs[7]  = '{OP_LAP,    0,   8'h12, 1'b1, 1, 8'h09, 0, 8'h10};
    vecs[8]  = '{OP_WAIT,   70,  8'h30, 1'b1, 0, 8'h00, 0, 8'h00};
    vecs[9]  = '{OP_RUN,    0,   8'h31, 1'b0, 0, 8'h00, 0, 8'h00};
    vecs[10] = '{OP_WAIT,   40,  8'h31, 1'b0, 0, 8'h00, 0, 8'h00};
    vecs[11] = '{OP_LAP,    0,   8'h00, 1'b0, 0, 8'h00, 0, 8'h00};
    vecs[12] = '{OP_NEXT,   0,   8'h00, 1'b0, 0, 8'h00, 1, 8'h00};
    vecs[13] = '{OP_RUN,    0,   8'h02, 1'b1, 0, 8'h00, 0, 8'h00};
    vecs[14] = '{OP_NEXT,   0,   8'h06, 1'b1, 0, 8'h00, 1, 8'h00};
    vecs[15] = '{OP_RUNLAP, 0,   8'h07, 1'b0, 1, 8'h07, 0, 8'h07};

    // Reset held while buttons toggle.
    for (int k = 0; k < 10; k++) begin
      btn_run = k[0]; btn_lap = k[1]; btn_next = ~k[0];
      @(negedge clk);
      chk("reset_hold_outputs", {time_bcd, running, sample_in, sample_in_valid, next_sample}, '0);
    end

    // All buttons held across reset release: no press.
    btn_run = 1'b1; btn_lap = 1'b1; btn_next = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (sample_in_valid || next_sample || running) cnt++;
    end
    chk("held_through_reset", cnt, 0);
    btn_run = 1'b0; btn_lap = 1'b0; btn_next = 1'b0;
    repeat (12) @(negedge clk);
    chk("after_release_time", time_bcd, 8'h00);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].op == OP_WAIT) begin
        repeat (vecs[i].cycles) @(negedge clk);
      end else begin
        do_press(vecs[i].op == OP_RUN || vecs[i].op == OP_RUNLAP,
                 vecs[i].op == OP_LAP || vecs[i].op == OP_RUNLAP,
                 vecs[i].op == OP_NEXT, nv, nn, cap, tcap, pos);
        chk($sformatf("v%0d_valid_pulses", i), nv, vecs[i].exp_valid);
        chk($sformatf("v%0d_next_pulses", i), nn, vecs[i].exp_next);
        if (vecs[i].exp_valid != 0) begin
          chk($sformatf("v%0d_sample_in", i), cap, vecs[i].exp_sample);
          chk($sformatf("v%0d_time_at_strobe", i), tcap, vecs[i].exp_tcap);
        end
        if (vecs[i].exp_valid != 0 || vecs[i].exp_next != 0)
          chk($sformatf("v%0d_strobe_pos", i), pos, 6);
      end
      chk($sformatf("v%0d_time_bcd", i), time_bcd, vecs[i].exp_time);
      chk($sformatf("v%0d_running", i), running, vecs[i].exp_run);
    end

    // Two-cycle glitch on next: filtered only with debounce.
    btn_next = 1'b1;
    repeat (2) @(negedge clk);
    btn_next = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (next_sample) cnt++;
    end
    chk("glitch_next_pulses", cnt, (LAT == 5) ? 0 : 1);

    // Next held 50 cycles: one pulse, registered at E+LAT.
    btn_next = 1'b1;
    cnt = 0; pos = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (next_sample) begin cnt++; pos = k; end
    end
    btn_next = 1'b0;
    chk("held_next_pulses", cnt, 1);
    chk("held_next_pos", pos, LAT + 1);
    repeat (12) @(negedge clk);

    // Reset asserted while the lap strobe is high.
    do_press(1'b1, 1'b0, 1'b0, nv, nn, cap, tcap, pos);
    chk("restart_running", running, 1'b1);
    btn_lap = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    chk("midstrobe_valid_before", sample_in_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("midstrobe_valid_after", sample_in_valid, 1'b0);
    chk("midstrobe_outputs", {time_bcd, running, sample_in, next_sample}, '0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (sample_in_valid) cnt++;
    end
    chk("post_reset_no_strobe", cnt, 0);
    btn_lap = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
